// File: rtl/rsb_pkg.sv
// rsb_pkg: shared constants and elaboration helpers for the ripple-borrow
// subtractor pipeline and its companion ripple-carry adder.
package rsb_pkg;

    // Default datapath width and slice width shared with the adder
    localparam int unsigned RSB_WIDTH = 16;
    localparam int unsigned RSB_M     = 4;

    // Number of pipeline stages: one stage per M-bit slice
    function automatic int unsigned rsb_stages(input int unsigned width, input int unsigned m);
        return (m == 0) ? 0 : width / m;
    endfunction

    // Legal configuration: nonzero slice width that evenly divides the datapath
    function automatic bit rsb_width_ok(input int unsigned width, input int unsigned m);
        return (m != 0) && (m <= width) && ((width % m) == 0);
    endfunction

endpackage

// File: rtl/rsb_stage.sv
// rsb_stage: one M-bit slice of the pipelined subtractor.
// Computes a + ~b + cin and registers result, carry-out and valid while en = 1.
module rsb_stage
    import rsb_pkg::*;
#(
    parameter int unsigned M = RSB_M
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    input  logic         cin,
    input  logic         vin,
    output logic [M-1:0] sum_q,
    output logic         cout_q,
    output logic         v_q
);

    logic [M:0] sum;

    // Slice subtract as add of the inverted subtrahend; bit M is the carry-out
    always_comb begin
        sum = {1'b0, a} + {1'b0, ~b} + {{M{1'b0}}, cin};
    end

    // Stage register; carry resets to 1 so an idle pipe reports no borrow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b1;
            v_q    <= 1'b0;
        end else if (en) begin
            sum_q  <= sum[M-1:0];
            cout_q <= sum[M];
            v_q    <= vin;
        end
    end

endmodule

// File: rtl/rsb_pipe.sv
// rsb_pipe: pipelined WIDTH-bit ripple-borrow subtractor, Diff = A - B,
// resolving one M-bit slice per stage with valid/ready on both sides.
// Optional signed-overflow output Ovf is built when RSB_OVF_EN is defined.
module rsb_pipe
    import rsb_pkg::*;
#(
    parameter int unsigned WIDTH = RSB_WIDTH,
    parameter int unsigned M     = RSB_M
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             B_out,
    output logic             out_valid,
    input  logic             out_ready
`ifdef RSB_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int unsigned STAGES = rsb_stages(WIDTH, M);

    logic adv;

    if (!rsb_width_ok(WIDTH, M)) begin : g_cfg_check
        $error("rsb_pipe: WIDTH must be a nonzero multiple of M");
    end

    // The whole pipe advances unless a valid result is blocked downstream
    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv;

    // Stage k sees operand bits [WIDTH-1:k*M] (skewed k cycles) and produces
    // word = result slices 0..k aligned to its own output register.
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        logic [WIDTH-1:k*M]     a_k;
        logic [WIDTH-1:k*M]     b_k;
        logic [(k+1)*M-1:0]     word;
        logic                   cin;
        logic                   vin;
        logic [M-1:0]           sum_q;
        logic                   cout_q;
        logic                   v_q;

        if (k == 0) begin : g_head
            assign a_k  = A;
            assign b_k  = B;
            assign cin  = 1'b1;
            assign vin  = in_valid;
            assign word = sum_q;
        end else begin : g_body
            logic [WIDTH-1:k*M] a_r;
            logic [WIDTH-1:k*M] b_r;
            logic [k*M-1:0]     w_r;

            // Skew remaining operand slices and deskew finished low slices by one stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_r <= '0;
                    b_r <= '0;
                    w_r <= '0;
                end else if (adv) begin
                    a_r <= g_st[k-1].a_k[WIDTH-1:k*M];
                    b_r <= g_st[k-1].b_k[WIDTH-1:k*M];
                    w_r <= g_st[k-1].word;
                end
            end

            assign a_k  = a_r;
            assign b_k  = b_r;
            assign cin  = g_st[k-1].cout_q;
            assign vin  = g_st[k-1].v_q;
            assign word = {sum_q, w_r};
        end

        rsb_stage #(.M(M)) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (adv),
            .a      (a_k[k*M +: M]),
            .b      (b_k[k*M +: M]),
            .cin    (cin),
            .vin    (vin),
            .sum_q  (sum_q),
            .cout_q (cout_q),
            .v_q    (v_q)
        );
    end

    assign Diff      = g_st[STAGES-1].word;
    assign B_out     = ~g_st[STAGES-1].cout_q;
    assign out_valid = g_st[STAGES-1].v_q;

`ifdef RSB_OVF_EN
    logic sgn_diff_q;
    logic a_msb_q;

    // Operand signs are captured as the top slice resolves so Ovf lines up with Diff
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sgn_diff_q <= 1'b0;
            a_msb_q    <= 1'b0;
        end else if (adv) begin
            sgn_diff_q <= g_st[STAGES-1].a_k[WIDTH-1] ^ g_st[STAGES-1].b_k[WIDTH-1];
            a_msb_q    <= g_st[STAGES-1].a_k[WIDTH-1];
        end
    end

    assign Ovf = sgn_diff_q && (Diff[WIDTH-1] != a_msb_q);
`endif

endmodule

// File: tb/tb_rsb_pipe.sv
// Self-checking bench for rsb_pipe (default build and with RSB_OVF_EN).
module tb_rsb_pipe;

    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main DUT, WIDTH=16, M=4
    logic [W-1:0] A, B, Diff;
    logic in_valid, in_ready, B_out, out_valid, out_ready;
`ifdef RSB_OVF_EN
    logic Ovf, s1_ovf, s16_ovf;
`endif

    // Sweep DUTs share operands: M=16 and M=1
    logic [W-1:0] s_a, s_b, s1_d, s16_d;
    logic s_v, s_or, s1_ir, s1_bo, s1_ov, s16_ir, s16_bo, s16_ov;

    rsb_pipe #(.WIDTH(16), .M(4)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .in_valid(in_valid), .in_ready(in_ready),
        .Diff(Diff), .B_out(B_out), .out_valid(out_valid), .out_ready(out_ready)
`ifdef RSB_OVF_EN
        , .Ovf(Ovf)
`endif
    );

    rsb_pipe #(.WIDTH(16), .M(16)) dut_m16 (
        .clk(clk), .rst_n(rst_n), .A(s_a), .B(s_b), .in_valid(s_v), .in_ready(s1_ir),
        .Diff(s1_d), .B_out(s1_bo), .out_valid(s1_ov), .out_ready(s_or)
`ifdef RSB_OVF_EN
        , .Ovf(s1_ovf)
`endif
    );

    rsb_pipe #(.WIDTH(16), .M(1)) dut_m1 (
        .clk(clk), .rst_n(rst_n), .A(s_a), .B(s_b), .in_valid(s_v), .in_ready(s16_ir),
        .Diff(s16_d), .B_out(s16_bo), .out_valid(s16_ov), .out_ready(s_or)
`ifdef RSB_OVF_EN
        , .Ovf(s16_ovf)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [16:0] exp_q[$];
    logic [16:0] obs_q[$];
    int          in_cyc_q[$];
    int          out_cyc_q[$];
    bit          ovf_exp_q[$];
    bit          ovf_obs_q[$];

    // Reference: {borrow, difference} from plain integer arithmetic
    function automatic logic [16:0] ref_sub(input logic [15:0] a, input logic [15:0] b);
        int d;
        logic [31:0] ud;
        logic br;
        d  = int'(a) - int'(b);
        br = (d < 0);
        if (d < 0) d = d + 65536;
        ud = d;
        return {br, ud[15:0]};
    endfunction

    // Reference: two's-complement overflow from signed integer arithmetic
    function automatic bit ref_ovf(input logic [15:0] a, input logic [15:0] b);
        int sd;
        sd = int'($signed(a)) - int'($signed(b));
        return (sd > 32767) || (sd < -32768);
    endfunction

    task automatic clear_sb();
        exp_q.delete(); obs_q.delete(); in_cyc_q.delete(); out_cyc_q.delete();
        ovf_exp_q.delete(); ovf_obs_q.delete();
    endtask

    // One clock on the main DUT: record transfers at mid-cycle, return at edge+1
    task automatic step();
        #4;
        if (in_valid && in_ready) begin
            exp_q.push_back(ref_sub(A, B));
            ovf_exp_q.push_back(ref_ovf(A, B));
            in_cyc_q.push_back(cyc);
        end
        if (out_valid && out_ready) begin
            obs_q.push_back({B_out, Diff});
`ifdef RSB_OVF_EN
            ovf_obs_q.push_back(Ovf);
`endif
            out_cyc_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_async_valid: got %0b, expected 0", out_valid); end
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b, expected 0", out_valid); end
        checks++; if (Diff !== 16'h0000) begin errors++; $display("FAIL reset_diff: got %h, expected 0000", Diff); end
        checks++; if (B_out !== 1'b0) begin errors++; $display("FAIL reset_b_out: got %0b, expected 0", B_out); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b, expected 1", in_ready); end
        checks++; if ({s1_ov, s16_ov, s1_ir, s16_ir} !== 4'b0011) begin errors++; $display("FAIL reset_sweep: got valid/ready %b, expected 0011", {s1_ov, s16_ov, s1_ir, s16_ir}); end
`ifdef RSB_OVF_EN
        checks++; if (Ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b, expected 0", Ovf); end
`endif
    endtask

    task automatic test_single();
        int g;
        clear_sb();
        out_ready = 1'b1;
        A = 16'd16; B = 16'd16; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        g = 0;
        while (obs_q.size() == 0 && g < 20) begin step(); g++; end
        checks++;
        if (obs_q.size() != 1) begin
            errors++; $display("FAIL single_count: got %0d results, expected 1", obs_q.size());
        end else begin
            checks++; if (obs_q[0] !== 17'h00000) begin errors++; $display("FAIL single_value: got B_out=%0b Diff=%h, expected B_out=0 Diff=0000", obs_q[0][16], obs_q[0][15:0]); end
            checks++; if (out_cyc_q[0] - in_cyc_q[0] != 4) begin errors++; $display("FAIL single_latency: got %0d, expected 4", out_cyc_q[0] - in_cyc_q[0]); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pulse: out_valid %0b one cycle later, expected 0", out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ta[4];
        logic [15:0] tbv[4];
        logic [16:0] te[4];
        int g;
        ta  = '{16'd65, 16'd5, 16'd2, 16'd0};
        tbv = '{16'd55, 16'd2, 16'd5, 16'd1};
        te  = '{17'h0000A, 17'h00003, 17'h1FFFD, 17'h1FFFF};
        clear_sb();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            A = ta[i]; B = tbv[i]; in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        g = 0;
        while (obs_q.size() < 4 && g < 20) begin step(); g++; end
        checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL b2b_count: got %0d results, expected 4", obs_q.size()); end
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== te[i]) begin errors++; $display("FAIL b2b_value[%0d]: got B_out=%0b Diff=%h, expected B_out=%0b Diff=%h", i, obs_q[i][16], obs_q[i][15:0], te[i][16], te[i][15:0]); end
            checks++; if (out_cyc_q[i] - in_cyc_q[0] != 4 + i) begin errors++; $display("FAIL b2b_timing[%0d]: got cycle %0d, expected %0d", i, out_cyc_q[i] - in_cyc_q[0], 4 + i); end
        end
    endtask

    task automatic test_stall();
        logic [15:0] sa[8];
        logic [15:0] sb[8];
        logic [17:0] snap;
        int idx, stall_left, g;
        bit stalled;
        for (int i = 0; i < 8; i++) begin sa[i] = 16'($urandom); sb[i] = 16'($urandom); end
        clear_sb();
        idx = 0; stall_left = 0; stalled = 0; g = 0; snap = '0;
        while ((idx < 8 || obs_q.size() < exp_q.size()) && g < 100) begin
            in_valid = (idx < 8);
            if (idx < 8) begin A = sa[idx]; B = sb[idx]; end
            if (!stalled && idx >= 5 && out_valid) begin
                stall_left = 3; stalled = 1; snap = {out_valid, B_out, Diff};
            end
            out_ready = (stall_left == 0);
            #1;
            if (stall_left > 0) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %0b, expected 0", in_ready); end
                checks++; if ({out_valid, B_out, Diff} !== snap) begin errors++; $display("FAIL stall_frozen: got %h, expected %h", {out_valid, B_out, Diff}, snap); end
                stall_left--;
            end
            step();
            idx = exp_q.size();
            g++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (!stalled) begin errors++; $display("FAIL stall_entered: stall window got 0, expected 1"); end
        checks++; if (obs_q.size() != 8 || exp_q.size() != 8) begin errors++; $display("FAIL stall_count: got %0d results for %0d inputs, expected 8", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_value[%0d]: got B_out=%0b Diff=%h, expected B_out=%0b Diff=%h", i, obs_q[i][16], obs_q[i][15:0], exp_q[i][16], exp_q[i][15:0]); end
        end
    endtask

    task automatic test_reset_mid();
        clear_sb();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            A = 16'($urandom); B = 16'($urandom); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_during: got out_valid %0b, expected 0", out_valid); end
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_edge: got out_valid %0b, expected 0", out_valid); end
        #3 rst_n = 1'b1;
        exp_q.delete(); in_cyc_q.delete(); ovf_exp_q.delete();
        @(posedge clk);
        #1;
        for (int i = 0; i < 12; i++) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_after[%0d]: got out_valid %0b, expected 0", i, out_valid); end
            step();
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rstmid_stale: got %0d results, expected 0", obs_q.size()); end
    endtask

    task automatic test_sweep();
        int n, lat1, lat16;
        logic [16:0] r1, r16, e;
`ifdef RSB_OVF_EN
        bit o1, o16;
        o1 = 0; o16 = 0;
`endif
        s_or = 1'b1;
        s_a = 16'h8000; s_b = 16'h0001; s_v = 1'b1;
        e = ref_sub(s_a, s_b);
        @(posedge clk);
        #1;
        s_v = 1'b0;
        n = 1; lat1 = -1; lat16 = -1; r1 = '0; r16 = '0;
        while ((lat1 < 0 || lat16 < 0) && n <= 40) begin
            if (s1_ov && lat1 < 0) begin
                lat1 = n; r1 = {s1_bo, s1_d};
`ifdef RSB_OVF_EN
                o1 = s1_ovf;
`endif
            end
            if (s16_ov && lat16 < 0) begin
                lat16 = n; r16 = {s16_bo, s16_d};
`ifdef RSB_OVF_EN
                o16 = s16_ovf;
`endif
            end
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (lat1 != 1) begin errors++; $display("FAIL sweep_m16_latency: got %0d, expected 1", lat1); end
        checks++; if (lat16 != 16) begin errors++; $display("FAIL sweep_m1_latency: got %0d, expected 16", lat16); end
        checks++; if (r1 !== e) begin errors++; $display("FAIL sweep_m16_value: got %h, expected %h", r1, e); end
        checks++; if (r16 !== e) begin errors++; $display("FAIL sweep_m1_value: got %h, expected %h", r16, e); end
`ifdef RSB_OVF_EN
        checks++; if ({o1, o16} !== 2'b11) begin errors++; $display("FAIL sweep_ovf: got %b, expected 11", {o1, o16}); end
`endif
    endtask

    task automatic test_random();
        int g;
        logic [15:0] pick[4];
        clear_sb();
        for (int i = 0; i < 300; i++) begin
            pick = '{16'h0000, 16'hFFFF, 16'h8000, 16'($urandom)};
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            A = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : 16'($urandom);
            B = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : 16'($urandom);
            #1;
            if (out_ready) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rand_in_ready[%0d]: got %0b, expected 1", i, in_ready); end
            end
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        g = 0;
        while (obs_q.size() < exp_q.size() && g < 40) begin step(); g++; end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d results, expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_value[%0d]: got B_out=%0b Diff=%h, expected B_out=%0b Diff=%h", i, obs_q[i][16], obs_q[i][15:0], exp_q[i][16], exp_q[i][15:0]); end
        end
    endtask

`ifdef RSB_OVF_EN
    task automatic test_ovf();
        logic [15:0] oa[3];
        logic [15:0] ob[3];
        bit          oe[3];
        int g;
        oa = '{16'h8000, 16'h7FFF, 16'h0005};
        ob = '{16'h0001, 16'hFFFF, 16'h0002};
        oe = '{1'b1, 1'b1, 1'b0};
        clear_sb();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            A = oa[i]; B = ob[i]; in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        g = 0;
        while (obs_q.size() < 3 && g < 20) begin step(); g++; end
        checks++; if (ovf_obs_q.size() != 3) begin errors++; $display("FAIL ovf_count: got %0d, expected 3", ovf_obs_q.size()); end
        for (int i = 0; i < 3 && i < ovf_obs_q.size(); i++) begin
            checks++; if (ovf_obs_q[i] !== oe[i] || ovf_obs_q[i] !== ovf_exp_q[i]) begin errors++; $display("FAIL ovf_value[%0d]: got %0b, expected %0b", i, ovf_obs_q[i], oe[i]); end
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_diff[%0d]: got %h, expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask
`endif

    initial begin
        in_valid = 1'b0; A = '0; B = '0; out_ready = 1'b1;
        s_a = '0; s_b = '0; s_v = 1'b0; s_or = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_sweep();
        test_random();
`ifdef RSB_OVF_EN
        test_ovf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
